// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-synchronous value commit
module seg_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic                  blank_lz,
    output logic [3:0]            hex_out,
    output logic [N_DIGITS-1:0]   an,
    output logic                  pending,
    output logic [2:0]            digit_idx
);

    typedef enum logic {
        DRIVE = 1'b0,
        GAP   = 1'b1
    } state_t;

    localparam logic [19:0] DIV_LAST = 20'(DIV - 1);
    localparam logic [2:0]  IDX_LAST = 3'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_RESET = {{(N_DIGITS-1){1'b1}}, 1'b0};

    state_t                  state, state_next;
    logic [19:0]             cnt, cnt_next;
    logic [2:0]              idx_next;
    logic [4*N_DIGITS-1:0]   shadow, shadow_next;
    logic [4*N_DIGITS-1:0]   pend_reg, pend_next;
    logic                    pending_next;
    logic [3:0]              hex_next;
    logic [N_DIGITS-1:0]     an_next;
    logic [N_DIGITS-1:0]     zero_from;
    logic                    zero_acc;

    // Outputs are computed from next-cycle state so the registered values line up with state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = digit_idx;
        shadow_next  = shadow;
        pend_next    = pend_reg;
        pending_next = pending;
        hex_next     = 4'h0;
        an_next      = '1;
        zero_from    = '0;
        zero_acc     = 1'b1;

        case (state)
            DRIVE: begin
                if (cnt == DIV_LAST) begin
                    state_next = GAP;
                    cnt_next   = 20'd0;
                end else begin
                    cnt_next = cnt + 20'd1;
                end
            end
            GAP: begin
                state_next = DRIVE;
                if (digit_idx == IDX_LAST) begin
                    idx_next = 3'd0;
                    if (pending) begin
                        shadow_next  = pend_reg;
                        pending_next = 1'b0;
                    end
                end else begin
                    idx_next = digit_idx + 3'd1;
                end
            end
            default: state_next = DRIVE;
        endcase

        // A load coinciding with a commit lands after it, so pending stays set.
        if (load) begin
            pend_next    = data_in;
            pending_next = 1'b1;
        end

        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc && (shadow_next[4*i +: 4] == 4'h0);
            zero_from[i] = zero_acc;
        end

        if (state_next == DRIVE) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (idx_next == 3'(i)) begin
                    hex_next = shadow_next[4*i +: 4];
                    if (!(blank_lz && (i != 0) && zero_from[i])) begin
                        an_next[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRIVE;
            cnt       <= 20'd0;
            digit_idx <= 3'd0;
            shadow    <= '0;
            pend_reg  <= '0;
            pending   <= 1'b0;
            hex_out   <= 4'h0;
            an        <= AN_RESET;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            digit_idx <= idx_next;
            shadow    <= shadow_next;
            pend_reg  <= pend_next;
            pending   <= pending_next;
            hex_out   <= hex_next;
            an        <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (4 digits, DIV=4)
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic        blank_lz;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        pending;
    logic [2:0]  digit_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int s     = 0;

    seg_scan_ctrl #(.N_DIGITS(4), .DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_in   (data_in),
        .blank_lz  (blank_lz),
        .hex_out   (hex_out),
        .an        (an),
        .pending   (pending),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (sample %0d)", tag, obs, exp, s);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        s++;
    endtask

    task automatic adv_to(input int phase);
        while ((s % 20) != phase) tick();
    endtask

    // One frame = 4 digits x (4 drive + 1 gap) = 20 samples, starting at a frame boundary.
    task automatic check_frame(input logic [15:0] sh, input logic bl);
        for (int k = 0; k < 20; k++) begin
            int p;
            int d;
            logic [3:0] nib;
            logic [15:0] upper;
            logic [3:0] exp_an;
            p = s % 5;
            d = (s / 5) % 4;
            nib = sh[4*d +: 4];
            upper = sh >> (4 * d);
            if (p < 4) begin
                exp_an = 4'hF;
                if (!(bl && d > 0 && upper == 16'h0)) exp_an[d] = 1'b0;
                chk("an_drive", 32'(an), 32'(exp_an));
                chk("hex_drive", 32'(hex_out), 32'(nib));
                chk("idx_drive", 32'(digit_idx), 32'(d));
            end else begin
                chk("an_gap", 32'(an), 32'hF);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        data_in = 16'h0;
        blank_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_hex", 32'(hex_out), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        rst = 1'b0;
        s = 0;

        // idle scan after reset: 1110,1111,1101,1111,1011,1111,0111,1111
        check_frame(16'h0000, 1'b0);

        // single load mid-frame waits for the wrap gap
        adv_to(3);
        load = 1'b1; data_in = 16'h1A3F;
        tick();
        load = 1'b0;
        chk("pend_after_load", 32'(pending), 32'h1);
        chk("no_tear_hex", 32'(hex_out), 32'h0);
        adv_to(19);
        chk("pend_at_wrap_gap", 32'(pending), 32'h1);
        tick();
        chk("pend_after_commit", 32'(pending), 32'h0);
        check_frame(16'h1A3F, 1'b0);

        // leading-zero blanking
        load = 1'b1; data_in = 16'h0070; blank_lz = 1'b1;
        tick();
        load = 1'b0;
        adv_to(0);
        check_frame(16'h0070, 1'b1);
        load = 1'b1; data_in = 16'h0000;
        tick();
        load = 1'b0;
        adv_to(0);
        check_frame(16'h0000, 1'b1);

        // last load in a frame wins
        blank_lz = 1'b0;
        load = 1'b1; data_in = 16'h1111;
        tick();
        load = 1'b0;
        adv_to(8);
        load = 1'b1; data_in = 16'h2222;
        tick();
        load = 1'b0;
        adv_to(0);
        check_frame(16'h2222, 1'b0);

        // load on the exact wrap gap: old pending commits, new one waits
        adv_to(6);
        load = 1'b1; data_in = 16'h1234;
        tick();
        load = 1'b0;
        adv_to(19);
        load = 1'b1; data_in = 16'hBEEF;
        tick();
        load = 1'b0;
        chk("pend_commit_collide", 32'(pending), 32'h1);
        check_frame(16'h1234, 1'b0);
        chk("pend_after_beef", 32'(pending), 32'h0);
        check_frame(16'hBEEF, 1'b0);

        // reset during digit 2 with a value pending; load during reset is ignored
        load = 1'b1; data_in = 16'h5555;
        tick();
        load = 1'b0;
        adv_to(11);
        chk("pend_before_rst", 32'(pending), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_an", 32'(an), 32'hE);
        chk("rst_mid_hex", 32'(hex_out), 32'h0);
        chk("rst_mid_pending", 32'(pending), 32'h0);
        chk("rst_mid_idx", 32'(digit_idx), 32'h0);
        load = 1'b1; data_in = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        rst = 1'b0;
        s = 0;
        chk("rst_load_ignored", 32'(pending), 32'h0);
        check_frame(16'h0000, 1'b0);
        check_frame(16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000: clock cycles each digit is driven, legal range 2..2^20.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 LOAD  input  1  one-cycle strobe; captures DATA_IN into the pending register.
REQ-006 DATA_IN  input  4*N_DIGITS  hex nibbles; nibble i (bits 4i+3..4i) belongs to digit i; digit 0 is rightmost.
REQ-007 BLANK_LZ  input  1  when 1, leading-zero blanking is enabled.
REQ-008 HEX_OUT  output  4  nibble fed to the shared 7-segment decoder.
REQ-009 AN  output  N_DIGITS  active-low digit enables; at most one bit low at any time.
REQ-010 PENDING  output  1  high while a loaded value waits for the frame boundary.
REQ-011 DIGIT_IDX  output  3  index of the digit currently selected.

Function
REQ-012 State machine has two states: DRIVE (one digit enabled) and GAP (all digits off for exactly 1 cycle).
REQ-013 In DRIVE, a divider counter counts 0..DIV-1; on the cycle the count equals DIV-1, the next state is GAP and the counter returns to 0.
REQ-014 In GAP, AN is all ones, DIGIT_IDX increments (N_DIGITS-1 wraps to 0), and the next state is DRIVE.
REQ-015 One digit period is DIV+1 cycles; one frame is N_DIGITS*(DIV+1) cycles.
REQ-016 In DRIVE, HEX_OUT equals shadow nibble DIGIT_IDX, and AN bit DIGIT_IDX is 0 unless that digit is blanked.
REQ-017 Outputs are registered: HEX_OUT, AN and DIGIT_IDX change only on clock edges and are glitch-free.
REQ-018 Leading-zero blanking: with BLANK_LZ=1, digit i>0 is blanked (AN bit stays 1) when shadow nibbles i..N_DIGITS-1 are all zero; digit 0 is never blanked.
REQ-019 LOAD=1 writes DATA_IN into the pending register and sets PENDING=1 on the next edge.
REQ-020 LOAD while PENDING=1 overwrites the pending register; PENDING stays 1; the last LOAD wins.
REQ-021 Frame commit occurs on the GAP cycle in which DIGIT_IDX wraps from N_DIGITS-1 to 0; if PENDING=1, shadow <= pending register and PENDING clears.
REQ-022 LOAD in the same cycle as a commit: the commit uses the old pending value; the new DATA_IN is captured; PENDING remains 1.
REQ-023 The shadow register never changes mid-frame, so a displayed value never tears.
REQ-024 BLANK_LZ is sampled every cycle; a change takes effect on the next DRIVE cycle.

Reset
REQ-025 RST=1 forces immediately: state DRIVE, counter 0, DIGIT_IDX 0, shadow 0, pending register 0, PENDING 0, HEX_OUT 0, AN = all ones except bit 0 = 0.
REQ-026 RST asserted mid-frame or mid-GAP discards any pending value; scanning restarts at digit 0 on the first edge after release.
REQ-027 LOAD during RST is ignored.

Verification (N_DIGITS=4, DIV=4)
REQ-028 After reset, no LOAD -> AN sequence 1110 (4 cycles), 1111 (1), 1101 (4), 1111 (1), 1011, 1111, 0111, 1111, then repeats; HEX_OUT=0 throughout DRIVE.
REQ-029 LOAD with DATA_IN=16'h1A3F mid-frame -> PENDING=1 until the wrap GAP; next frame HEX_OUT shows F,3,A,1 on digits 0..3; PENDING=0.
REQ-030 BLANK_LZ=1, shadow 16'h0070 -> digits 2 and 3 keep AN bit high; digits 0 and 1 are driven; digit 0 is still driven with shadow 16'h0000.
REQ-031 Two LOADs (16'h1111, then 16'h2222) in one frame -> next frame shows 2222; value 1111 never appears.
REQ-032 LOAD 16'hBEEF on the exact wrap GAP cycle with pending 16'h1234 -> that frame shows 1234; PENDING=1; the following frame shows BEEF.
REQ-033 RST pulse during digit 2 with PENDING=1 -> AN=1110, HEX_OUT=0, PENDING=0 immediately; normal scan resumes after release.
